pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined CPU. Gates PC and pipeline-register writes, and inserts bubbles for load-use hazards and taken branches resolved in MEM. Runs a request/acknowledge handshake with the data memory so multi-cycle memory latency freezes the pipeline. Holds the pipeline empty until start_i, and keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake/control bundle between the pipeline datapath and the hazard sequencer.
// The master is the datapath side; the slave is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_uses_rs2_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_addr_i;
  logic             mem_branch_taken_i;
  logic             mem_access_i;
  logic             mem_ack_i;

  logic             pc_write_o;
  logic             if_id_write_o;
  logic             id_ex_write_o;
  logic             ex_mem_write_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             ex_mem_flush_o;
  logic             mem_wb_bubble_o;
  logic             mem_req_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, id_rs1_addr_i, id_rs2_addr_i, id_uses_rs2_i, ex_memread_i,
           ex_rd_addr_i, mem_branch_taken_i, mem_access_i, mem_ack_i,
    input  pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, if_id_flush_o,
           id_ex_flush_o, ex_mem_flush_o, mem_wb_bubble_o, mem_req_o, err_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, id_rs1_addr_i, id_rs2_addr_i, id_uses_rs2_i, ex_memread_i,
           ex_rd_addr_i, mem_branch_taken_i, mem_access_i, mem_ack_i,
    output pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, if_id_flush_o,
           id_ex_flush_o, ex_mem_flush_o, mem_wb_bubble_o, mem_req_o, err_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-resolved
// branch flushes, data-memory wait freezing with timeout, and saturating counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALT} state_t;

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            r_state;
  state_t            w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_waitNext;
  logic              r_err;
  logic [CNT_W-1:0]  r_stallCnt;
  logic [CNT_W-1:0]  r_flushCnt;

  logic w_loadUse;
  logic w_pcWrite;
  logic w_ifIdWrite;
  logic w_idExWrite;
  logic w_exMemWrite;
  logic w_ifIdFlush;
  logic w_idExFlush;
  logic w_exMemFlush;
  logic w_bubble;
  logic w_memReq;
  logic w_flushEvt;
  logic w_stallEvt;

  assign w_loadUse = bus.ex_memread_i && (bus.ex_rd_addr_i != 5'd0) &&
                     ((bus.ex_rd_addr_i == bus.id_rs1_addr_i) ||
                      (bus.id_uses_rs2_i && (bus.ex_rd_addr_i == bus.id_rs2_addr_i)));

  assign w_waitNext = r_waitCnt + WAIT_W'(1);

  always_comb begin
    w_nextState  = r_state;
    w_pcWrite    = 1'b0;
    w_ifIdWrite  = 1'b0;
    w_idExWrite  = 1'b0;
    w_exMemWrite = 1'b0;
    w_ifIdFlush  = 1'b0;
    w_idExFlush  = 1'b0;
    w_exMemFlush = 1'b0;
    w_bubble     = 1'b0;
    w_memReq     = 1'b0;
    w_flushEvt   = 1'b0;

    case (r_state)
      IDLE: begin
        w_ifIdFlush  = 1'b1;
        w_idExFlush  = 1'b1;
        w_exMemFlush = 1'b1;
        w_bubble     = 1'b1;
        if (bus.start_i) w_nextState = RUN;
      end

      RUN: begin
        // A pending memory access outranks everything: it freezes the whole pipe.
        if (bus.mem_access_i) begin
          w_memReq = 1'b1;
          if (bus.mem_ack_i) begin
            w_pcWrite    = 1'b1;
            w_ifIdWrite  = 1'b1;
            w_idExWrite  = 1'b1;
            w_exMemWrite = 1'b1;
          end else begin
            w_bubble    = 1'b1;
            w_nextState = MEM_WAIT;
          end
        end else if (bus.mem_branch_taken_i) begin
          w_pcWrite    = 1'b1;
          w_ifIdWrite  = 1'b1;
          w_idExWrite  = 1'b1;
          w_exMemWrite = 1'b1;
          w_ifIdFlush  = 1'b1;
          w_idExFlush  = 1'b1;
          w_exMemFlush = 1'b1;
          w_flushEvt   = 1'b1;
        end else if (w_loadUse) begin
          w_idExWrite  = 1'b1;
          w_exMemWrite = 1'b1;
          w_idExFlush  = 1'b1;
        end else begin
          w_pcWrite    = 1'b1;
          w_ifIdWrite  = 1'b1;
          w_idExWrite  = 1'b1;
          w_exMemWrite = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (bus.mem_ack_i) begin
          w_pcWrite    = 1'b1;
          w_ifIdWrite  = 1'b1;
          w_idExWrite  = 1'b1;
          w_exMemWrite = 1'b1;
          w_nextState  = RUN;
        end else begin
          w_bubble = 1'b1;
          if (w_waitNext >= TIMEOUT_V) w_nextState = HALT;
        end
      end

      HALT: begin
        w_ifIdFlush  = 1'b1;
        w_idExFlush  = 1'b1;
        w_exMemFlush = 1'b1;
        w_bubble     = 1'b1;
      end
    endcase
  end

  assign w_stallEvt = ((r_state == RUN) || (r_state == MEM_WAIT)) && !w_pcWrite;

  // The request cycle itself counts as the first waiting cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_waitCnt  <= '0;
      r_err      <= 1'b0;
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == RUN) && bus.mem_access_i && !bus.mem_ack_i) begin
        r_waitCnt <= WAIT_W'(1);
      end else if (r_state == MEM_WAIT) begin
        r_waitCnt <= bus.mem_ack_i ? '0 : w_waitNext;
      end
      if (w_nextState == HALT) r_err <= 1'b1;
      if (w_stallEvt && (r_stallCnt != CNT_MAX)) r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_flushEvt && (r_flushCnt != CNT_MAX)) r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  assign bus.pc_write_o      = w_pcWrite;
  assign bus.if_id_write_o   = w_ifIdWrite;
  assign bus.id_ex_write_o   = w_idExWrite;
  assign bus.ex_mem_write_o  = w_exMemWrite;
  assign bus.if_id_flush_o   = w_ifIdFlush;
  assign bus.id_ex_flush_o   = w_idExFlush;
  assign bus.ex_mem_flush_o  = w_exMemFlush;
  assign bus.mem_wb_bubble_o = w_bubble;
  assign bus.mem_req_o       = w_memReq;
  assign bus.err_o           = r_err;
  assign bus.stall_cnt_o     = r_stallCnt;
  assign bus.flush_cnt_o     = r_flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs come from a behavioural model and are queued.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic       start;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       usesRs2;
    logic       exMemread;
    logic [4:0] exRd;
    logic       branch;
    logic       memAccess;
    logic       ack;
    logic       rst;
  } stim_t;

  typedef struct {
    bit pcWrite;
    bit ifIdWrite;
    bit idExWrite;
    bit exMemWrite;
    bit ifIdFlush;
    bit idExFlush;
    bit exMemFlush;
    bit bubble;
    bit memReq;
    bit err;
    int stallCnt;
    int flushCnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: whether started, whether halted, how many cycles the current memory access has stalled.
  bit isRunning;
  bit isHalted;
  int waitCycles;
  bit errSeen;
  int stalls;
  int flushes;

  function automatic void modelReset();
    isRunning  = 1'b0;
    isHalted   = 1'b0;
    waitCycles = 0;
    errSeen    = 1'b0;
    stalls     = 0;
    flushes    = 0;
  endfunction

  function automatic int satInc(int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic exp_t modelStep(stim_t s);
    exp_t e;
    bit hazard;
    e = '{default: 0};
    e.err      = errSeen;
    e.stallCnt = stalls;
    e.flushCnt = flushes;
    hazard = s.exMemread && (s.exRd != 0) &&
             ((s.exRd == s.rs1) || (s.usesRs2 && (s.exRd == s.rs2)));
    if (isHalted || !isRunning) begin
      e.ifIdFlush = 1; e.idExFlush = 1; e.exMemFlush = 1; e.bubble = 1;
      if (!isHalted && s.start) isRunning = 1'b1;
    end else if (waitCycles > 0) begin
      if (s.ack) begin
        e.pcWrite = 1; e.ifIdWrite = 1; e.idExWrite = 1; e.exMemWrite = 1;
        waitCycles = 0;
      end else begin
        e.bubble = 1;
        stalls = satInc(stalls);
        waitCycles++;
        if (waitCycles >= TIMEOUT) begin
          isHalted = 1'b1; isRunning = 1'b0; errSeen = 1'b1; waitCycles = 0;
        end
      end
    end else if (s.memAccess) begin
      e.memReq = 1;
      if (s.ack) begin
        e.pcWrite = 1; e.ifIdWrite = 1; e.idExWrite = 1; e.exMemWrite = 1;
      end else begin
        e.bubble = 1;
        stalls = satInc(stalls);
        waitCycles = 1;
      end
    end else if (s.branch) begin
      e.pcWrite = 1; e.ifIdWrite = 1; e.idExWrite = 1; e.exMemWrite = 1;
      e.ifIdFlush = 1; e.idExFlush = 1; e.exMemFlush = 1;
      flushes = satInc(flushes);
    end else if (hazard) begin
      e.idExWrite = 1; e.exMemWrite = 1; e.idExFlush = 1;
      stalls = satInc(stalls);
    end else begin
      e.pcWrite = 1; e.ifIdWrite = 1; e.idExWrite = 1; e.exMemWrite = 1;
    end
    if (s.rst) modelReset();
    return e;
  endfunction

  function automatic stim_t nopStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic applyStimulus(stim_t s);
    @(posedge clk_i);
    #1;
    rst_i                  = s.rst;
    bus.start_i            = s.start;
    bus.id_rs1_addr_i      = s.rs1;
    bus.id_rs2_addr_i      = s.rs2;
    bus.id_uses_rs2_i      = s.usesRs2;
    bus.ex_memread_i       = s.exMemread;
    bus.ex_rd_addr_i       = s.exRd;
    bus.mem_branch_taken_i = s.branch;
    bus.mem_access_i       = s.memAccess;
    bus.mem_ack_i          = s.ack;
    expQ.push_back(modelStep(s));
  endtask

  task automatic checkField(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(exp_t e);
    checkField("pc_write",    int'(bus.pc_write_o),      int'(e.pcWrite));
    checkField("if_id_write", int'(bus.if_id_write_o),   int'(e.ifIdWrite));
    checkField("id_ex_write", int'(bus.id_ex_write_o),   int'(e.idExWrite));
    checkField("ex_mem_write",int'(bus.ex_mem_write_o),  int'(e.exMemWrite));
    checkField("if_id_flush", int'(bus.if_id_flush_o),   int'(e.ifIdFlush));
    checkField("id_ex_flush", int'(bus.id_ex_flush_o),   int'(e.idExFlush));
    checkField("ex_mem_flush",int'(bus.ex_mem_flush_o),  int'(e.exMemFlush));
    checkField("mem_wb_bubble",int'(bus.mem_wb_bubble_o),int'(e.bubble));
    checkField("mem_req",     int'(bus.mem_req_o),       int'(e.memReq));
    checkField("err",         int'(bus.err_o),           int'(e.err));
    checkField("stall_cnt",   int'(bus.stall_cnt_o),     e.stallCnt);
    checkField("flush_cnt",   int'(bus.flush_cnt_o),     e.flushCnt);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    stim_t s;
    int    drain;
    rst_i = 1'b1;
    bus.start_i = 0; bus.id_rs1_addr_i = 0; bus.id_rs2_addr_i = 0; bus.id_uses_rs2_i = 0;
    bus.ex_memread_i = 0; bus.ex_rd_addr_i = 0; bus.mem_branch_taken_i = 0;
    bus.mem_access_i = 0; bus.mem_ack_i = 0;
    repeat (3) @(posedge clk_i);
    modelReset();

    repeat (5) applyStimulus(nopStim());
    s = nopStim(); s.start = 1; applyStimulus(s);
    applyStimulus(nopStim());

    s = nopStim(); s.exMemread = 1; s.exRd = 5; s.rs1 = 5; s.rs2 = 7; s.usesRs2 = 1;
    applyStimulus(s);
    applyStimulus(nopStim());
    s = nopStim(); s.exMemread = 1; s.exRd = 0; s.rs1 = 0; applyStimulus(s);
    s = nopStim(); s.exMemread = 1; s.exRd = 5; s.rs1 = 3; s.rs2 = 5; s.usesRs2 = 0;
    applyStimulus(s);
    s.usesRs2 = 1; applyStimulus(s);
    s = nopStim(); s.branch = 1; s.exMemread = 1; s.exRd = 5; s.rs1 = 5; applyStimulus(s);
    applyStimulus(nopStim());

    s = nopStim(); s.memAccess = 1;
    repeat (3) applyStimulus(s);
    s.ack = 1; applyStimulus(s);
    applyStimulus(s);
    s = nopStim(); s.ack = 1; applyStimulus(s);

    s = nopStim(); s.memAccess = 1; s.start = 1;
    repeat (4) applyStimulus(s);
    s = nopStim(); s.start = 1;
    repeat (2) applyStimulus(s);
    s = nopStim(); s.rst = 1; applyStimulus(s);
    applyStimulus(nopStim());

    s = nopStim(); s.start = 1; applyStimulus(s);
    s = nopStim(); s.memAccess = 1; applyStimulus(s);
    s.rst = 1; applyStimulus(s);
    s = nopStim(); s.memAccess = 1; applyStimulus(s);

    for (int i = 0; i < 1500; i++) begin
      int pick;
      s = nopStim();
      s.start     = ($urandom_range(0, 3) == 0);
      s.rs1       = 5'($urandom_range(0, 7));
      s.rs2       = 5'($urandom_range(0, 7));
      s.usesRs2   = 1'($urandom_range(0, 1));
      s.exMemread = 1'($urandom_range(0, 1));
      s.exRd      = 5'($urandom_range(0, 7));
      pick = $urandom_range(0, 9);
      s.memAccess = (pick < 3);
      s.branch    = (pick >= 3) && (pick < 5);
      s.ack       = ($urandom_range(0, 2) == 0);
      s.rst       = isHalted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      applyStimulus(s);
    end

    drain = 0;
    while ((expQ.size() > 0) && (drain < 10)) begin
      @(posedge clk_i);
      drain++;
    end
    checks++;
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: actual=%0d pending expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
